fir_coef_loader: RTL

- Initiator side of the FIR coefficient write interface: coef_rst, coef_wr_en, coef_wr_lsb_data, coef_wr_msb_data, taps_per_filter and wr_addr_zero.
- Accepts a byte stream from the host control path over a valid/ready handshake and packs byte pairs into 16-bit coefficients.
- Drives one write strobe per coefficient into the filter bank's coefficient RAMs.
- Closes each load with a checksum and an address-wrap check, then reports done or error.

---
 rtl/fir_coef_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Packs a host byte stream into 16-bit FIR coefficients, strobes each into the
// coefficient RAMs, and closes the load with an XOR checksum and address-wrap check.
module fir_coef_loader #(
    parameter int unsigned NUM_FILTERS = 4,
    parameter int unsigned WR_GAP      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic [7:0] taps_per_filter,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       wr_addr_zero,
    output logic       coef_rst,
    output logic       coef_wr_en,
    output logic [7:0] coef_wr_msb_data,
    output logic [7:0] coef_wr_lsb_data,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned GAP_W  = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WR_GAP - 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CKSUM = 2'd1;
    localparam logic [1:0] ERR_WRAP  = 2'd2;
    localparam logic [1:0] ERR_TAPS  = 2'd3;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CLR   = 4'd1;
    localparam logic [3:0] S_MSB   = 4'd2;
    localparam logic [3:0] S_LSB   = 4'd3;
    localparam logic [3:0] S_WRITE = 4'd4;
    localparam logic [3:0] S_GAP   = 4'd5;
    localparam logic [3:0] S_CKSUM = 4'd6;
    localparam logic [3:0] S_CHECK = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;
    localparam logic [3:0] S_ERR   = 4'd9;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       xor_q, xor_d;
    logic [7:0]       msb_q, msb_d;
    logic [7:0]       lsb_q, lsb_d;
    logic [1:0]       err_q, err_d;
    logic             byte_ready_q, byte_ready_d;
    logic             coef_rst_q, coef_rst_d;
    logic             coef_wr_en_q, coef_wr_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             xfer;

    assign xfer = byte_valid & byte_ready_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        count_d = count_q;
        gap_d   = gap_q;
        xor_d   = xor_q;
        msb_d   = msb_q;
        lsb_d   = lsb_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (taps_per_filter == 8'd0) begin
                        state_d = S_ERR;
                        err_d   = ERR_TAPS;
                    end else begin
                        state_d = S_CLR;
                        err_d   = ERR_NONE;
                        total_d = CNT_W'(NUM_FILTERS) * CNT_W'(taps_per_filter);
                    end
                end
            end
            S_CLR: begin
                xor_d   = 8'd0;
                count_d = '0;
                state_d = S_MSB;
            end
            S_MSB: begin
                if (xfer) begin
                    msb_d   = byte_data;
                    xor_d   = xor_q ^ byte_data;
                    state_d = S_LSB;
                end
            end
            S_LSB: begin
                if (xfer) begin
                    lsb_d   = byte_data;
                    xor_d   = xor_q ^ byte_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_q + CNT_W'(1);
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = (count_q == total_q) ? S_CKSUM : S_MSB;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_CKSUM: begin
                if (xfer) begin
                    if (byte_data != xor_q) begin
                        state_d = S_ERR;
                        err_d   = ERR_CKSUM;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (wr_addr_zero) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ERR;
                    err_d   = ERR_WRAP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes and ready are registered from the state being entered
        byte_ready_d = (state_d == S_MSB) || (state_d == S_LSB) || (state_d == S_CKSUM);
        coef_rst_d   = (state_d == S_CLR);
        coef_wr_en_d = (state_d == S_WRITE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            total_q      <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            xor_q        <= '0;
            msb_q        <= '0;
            lsb_q        <= '0;
            err_q        <= ERR_NONE;
            byte_ready_q <= 1'b0;
            coef_rst_q   <= 1'b0;
            coef_wr_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            xor_q        <= xor_d;
            msb_q        <= msb_d;
            lsb_q        <= lsb_d;
            err_q        <= err_d;
            byte_ready_q <= byte_ready_d;
            coef_rst_q   <= coef_rst_d;
            coef_wr_en_q <= coef_wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_ready       = byte_ready_q;
    assign coef_rst         = coef_rst_q;
    assign coef_wr_en       = coef_wr_en_q;
    assign coef_wr_msb_data = msb_q;
    assign coef_wr_lsb_data = lsb_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_code         = err_q;

endmodule
